result_checker: RTL and testbench
=================================

RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter WIDTH, default 32, width of the observed and expected data buses.
REQ-002 Parameter STABLE, default 3, consecutive matching samples required for a pass; legal range 1..TIMEOUT.
REQ-003 Parameter TIMEOUT, default 16, maximum samples taken per check before failing; legal range STABLE..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a check; sampled on the rising clk edge.
REQ-007 expected  input  WIDTH  value the observed bus must settle to; latched when start is accepted.
REQ-008 obs  input  WIDTH  DUT output under check, for example a generated FSM's out1.
REQ-009 busy  output  1  high while a check is in progress.
REQ-010 done  output  1  one-cycle pulse marking completion of a check.
REQ-011 pass  output  1  result of the most recent check; valid from done until the next accepted start.
REQ-012 last_obs  output  WIDTH  obs value taken at the final sample of the most recent check.
REQ-013 fail_count  output  8  number of failed checks since reset; saturates.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CHECK and REPORT.
REQ-015 In IDLE, start=1 SHALL latch expected, clear the match and sample counters, set busy, and move to CHECK.
REQ-016 start SHALL be ignored while busy=1; the latched expected value SHALL NOT change.
REQ-017 In CHECK, each edge SHALL take one sample and increment the sample counter.
  - obs==latched expected: the match counter increments.
  - mismatch: the match counter clears to 0.
REQ-018 The first sample SHALL be taken on the edge after the start edge.
REQ-019 On the edge whose sample raises the match count to STABLE, the block SHALL:
  - set pass=1 and done=1;
  - capture last_obs;
  - clear busy;
  - move to REPORT.
REQ-020 On the edge that takes the TIMEOUT-th sample without meeting REQ-019, the block SHALL:
  - set pass=0 and done=1;
  - capture last_obs;
  - increment fail_count;
  - clear busy;
  - move to REPORT.
REQ-021 When REQ-019 and REQ-020 are met on the same edge, the block SHALL pass and SHALL NOT increment fail_count.
REQ-022 fail_count SHALL saturate at 255 and SHALL NOT wrap to 0.
REQ-023 REPORT SHALL last exactly one cycle; done SHALL be low on the next edge and the FSM SHALL return to IDLE.
REQ-024 start asserted while in REPORT SHALL be ignored.
REQ-025 pass and last_obs SHALL hold their values until the next accepted start; accepting start SHALL clear pass to 0.
REQ-026 obs SHALL be compared over the full WIDTH bits, with no masking.

Reset
REQ-027 reset=1 SHALL immediately force the FSM to IDLE, independent of clk.
REQ-028 While reset=1, the block SHALL drive:
  - busy=0, done=0, pass=0;
  - last_obs=0, fail_count=0;
  - all internal counters and the latched expected value to 0.
REQ-029 Reset asserted during CHECK or REPORT SHALL abort the check with no done pulse and no fail_count change.
REQ-030 After reset deasserts, the first start SHALL be accepted on the first rising edge that samples it.

Configuration
REQ-031 With macro RESULT_CHECKER_TRACE_EN defined, the block SHALL print one simulation line on each done pulse.
  - Content: PASS or FAIL, the latched expected value and last_obs, in hex.
REQ-032 Without RESULT_CHECKER_TRACE_EN defined, the block SHALL contain no display statements.
REQ-033 The macro SHALL NOT alter any port behaviour or cycle timing.

Verification
REQ-034 Defaults; start with expected=0x19; obs=0x19 held constant -> done at the 3rd edge after start, pass=1, last_obs=0x19, fail_count=0.
REQ-035 Defaults; expected=0x04; obs=0x0F held constant -> done at the 16th edge after start, pass=0, last_obs=0x0F, fail_count=1.
REQ-036 Defaults; expected=0x19; obs sequence 0x19,0x19,0x0F,0x19,0x19,0x19 -> done at the 6th edge, pass=1; start pulsed mid-check has no effect.
REQ-037 STABLE=TIMEOUT=4; obs matches from the first sample -> pass=1 on the 4th edge, fail_count unchanged.
REQ-038 Reset at the 5th edge of a failing check -> no done pulse, all outputs 0; a following passing check completes normally.
REQ-039 256 consecutive failing checks -> fail_count reads 255 after the 255th check and after the 256th.

Source files
------------

// File: rtl/result_checker.sv
// result_checker
// Watches a DUT output bus and decides whether it settles to an expected
// value. A check is requested with start. The expected value is latched at
// that point. The observed bus is then sampled once per clock. The check
// passes once STABLE consecutive samples match the latched value. It fails
// if TIMEOUT samples go by without that happening. Failed checks are counted
// in a saturating 8-bit counter.
//
// Parameters
//   WIDTH    width of expected/obs/last_obs
//   STABLE   consecutive matching samples needed for a pass (1..TIMEOUT)
//   TIMEOUT  maximum samples per check before failing (STABLE..255)
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-high reset
//   start       request a check (ignored unless idle)
//   expected    value obs must settle to, latched on an accepted start
//   obs         bus under check
//   busy        high while a check is in progress
//   done        one-cycle pulse when a check completes
//   pass        result of the most recent check
//   last_obs    obs value at the final sample of the most recent check
//   fail_count  failed checks since reset, saturates at 255
//
// Optional feature
//   RESULT_CHECKER_TRACE_EN  when defined, prints one line per done pulse
//                            (simulation only, no effect on ports or timing)

module result_checker #(
   parameter int WIDTH   = 32,
   parameter int STABLE  = 3,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] expected,
   input  logic [WIDTH-1:0] obs,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] last_obs,
   output logic [7:0]       fail_count
);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      REPORT
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] exp_q;
   logic [7:0]       match_cnt;
   logic [7:0]       sample_cnt;

   logic             sample_hit;
   logic [8:0]       match_inc;
   logic [8:0]       sample_inc;
   logic             stable_met;
   logic             timeout_met;
   logic             start_accept;
   logic             check_pass;
   logic             check_fail;

   // State register; reset forces IDLE immediately, independent of clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-edge decisions. Counters are widened by one bit so
   // that comparing against STABLE/TIMEOUT never wraps. A pass takes
   // priority over a timeout that lands on the same sample.
   always_comb begin
      state_next   = state;
      start_accept = 1'b0;
      check_pass   = 1'b0;
      check_fail   = 1'b0;
      sample_hit   = (obs == exp_q);
      match_inc    = {1'b0, match_cnt} + 9'd1;
      sample_inc   = {1'b0, sample_cnt} + 9'd1;
      stable_met   = sample_hit && (match_inc == 9'(STABLE));
      timeout_met  = (sample_inc == 9'(TIMEOUT));

      case (state)
         IDLE: begin
            if (start) begin
               start_accept = 1'b1;
               state_next   = CHECK;
            end
         end
         CHECK: begin
            if (stable_met) begin
               check_pass = 1'b1;
               state_next = REPORT;
            end else if (timeout_met) begin
               check_fail = 1'b1;
               state_next = REPORT;
            end
         end
         REPORT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: the latched expected value, the counters and the result
   // registers. The result registers hold until the next accepted start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q      <= '0;
         match_cnt  <= '0;
         sample_cnt <= '0;
         pass       <= 1'b0;
         last_obs   <= '0;
         fail_count <= '0;
      end else if (start_accept) begin
         exp_q      <= expected;
         match_cnt  <= '0;
         sample_cnt <= '0;
         pass       <= 1'b0;
      end else if (state == CHECK) begin
         match_cnt  <= sample_hit ? match_inc[7:0] : 8'd0;
         sample_cnt <= sample_inc[7:0];
         if (check_pass) begin
            pass     <= 1'b1;
            last_obs <= obs;
         end
         if (check_fail) begin
            last_obs <= obs;
            if (fail_count != 8'hFF) begin
               fail_count <= fail_count + 8'd1;
            end
         end
      end
   end

   // busy and done are decoded straight from the state. REPORT lasts
   // exactly one cycle, so done is a single-cycle pulse.
   assign busy = (state == CHECK);
   assign done = (state == REPORT);

`ifdef RESULT_CHECKER_TRACE_EN
   // Simulation trace of each completed check.
   always @(posedge clk) begin
      if (!reset && done) begin
         $display("result_checker %m: %s expected=%h last_obs=%h",
                  pass ? "PASS" : "FAIL", exp_q, last_obs);
      end
   end
`endif

endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker
// Directed testbench for result_checker. Instance dut uses the default
// parameters. Instance dut2 uses STABLE=TIMEOUT=4. Each scenario task drives
// its own stimulus and compares the outputs against hand-computed values.
// Outputs are sampled 1 time unit after the rising edge.

module tb_result_checker;

   logic        clk;
   logic        reset;

   logic        start;
   logic [31:0] expected;
   logic [31:0] obs;
   logic        busy;
   logic        done;
   logic        pass;
   logic [31:0] last_obs;
   logic [7:0]  fail_count;

   logic        start2;
   logic [31:0] expected2;
   logic [31:0] obs2;
   logic        busy2;
   logic        done2;
   logic        pass2;
   logic [31:0] last_obs2;
   logic [7:0]  fail_count2;

   int checks;
   int errors;

   result_checker dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .expected   (expected),
      .obs        (obs),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .last_obs   (last_obs),
      .fail_count (fail_count)
   );

   result_checker #(.WIDTH(32), .STABLE(4), .TIMEOUT(4)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .start      (start2),
      .expected   (expected2),
      .obs        (obs2),
      .busy       (busy2),
      .done       (done2),
      .pass       (pass2),
      .last_obs   (last_obs2),
      .fail_count (fail_count2)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset holds every output at zero.
   task automatic test_reset();
      reset = 1'b1;
      #22;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass: got %0b want 0", pass); end
      checks++; if (last_obs !== 32'h0) begin errors++; $display("[TB] FAIL reset_last_obs: got %h want 0", last_obs); end
      checks++; if (fail_count !== 8'h0) begin errors++; $display("[TB] FAIL reset_fail_count: got %0d want 0", fail_count); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy2: got %0b want 0", busy2); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   // Constant matching obs gives done on the 3rd edge. Start during REPORT is ignored.
   task automatic test_pass();
      expected = 32'h19; obs = 32'h19; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pass_busy_after_start: got %0b want 1", busy); end
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         checks++; if (done !== (k == 3)) begin errors++; $display("[TB] FAIL pass_done_edge%0d: got %0b want %0b", k, done, (k == 3)); end
      end
      checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL pass_pass: got %0b want 1", pass); end
      checks++; if (last_obs !== 32'h19) begin errors++; $display("[TB] FAIL pass_last_obs: got %h want 19", last_obs); end
      checks++; if (fail_count !== 8'd0) begin errors++; $display("[TB] FAIL pass_fail_count: got %0d want 0", fail_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL pass_busy_at_done: got %0b want 0", busy); end
      start = 1'b1; expected = 32'h77;
      @(posedge clk); #1; start = 1'b0;
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL report_done_one_cycle: got %0b want 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL report_start_ignored: got busy %0b want 0", busy); end
      checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL report_pass_hold: got %0b want 1", pass); end
   endtask

   // Constant mismatching obs fails on the 16th edge.
   task automatic test_fail();
      expected = 32'h04; obs = 32'h0F; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL fail_pass_cleared: got %0b want 0", pass); end
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         checks++; if (done !== (k == 16)) begin errors++; $display("[TB] FAIL fail_done_edge%0d: got %0b want %0b", k, done, (k == 16)); end
      end
      checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL fail_pass: got %0b want 0", pass); end
      checks++; if (last_obs !== 32'h0F) begin errors++; $display("[TB] FAIL fail_last_obs: got %h want 0f", last_obs); end
      checks++; if (fail_count !== 8'd1) begin errors++; $display("[TB] FAIL fail_fail_count: got %0d want 1", fail_count); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL fail_done_low: got %0b want 0", done); end
   endtask

   // A mismatch restarts the match run. A start pulse mid-check must not relatch expected.
   task automatic test_mid_start();
      logic [31:0] seq [6];
      seq = '{32'h19, 32'h19, 32'h0F, 32'h19, 32'h19, 32'h19};
      expected = 32'h19; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         obs = seq[k-1];
         if (k == 2) begin start = 1'b1; expected = 32'h0F; end
         if (k == 4) begin start = 1'b0; expected = 32'h19; end
         @(posedge clk); #1;
         checks++; if (done !== (k == 6)) begin errors++; $display("[TB] FAIL mid_done_edge%0d: got %0b want %0b", k, done, (k == 6)); end
      end
      checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL mid_pass: got %0b want 1", pass); end
      checks++; if (last_obs !== 32'h19) begin errors++; $display("[TB] FAIL mid_last_obs: got %h want 19", last_obs); end
      checks++; if (fail_count !== 8'd1) begin errors++; $display("[TB] FAIL mid_fail_count: got %0d want 1", fail_count); end
      @(posedge clk); #1;
   endtask

   // STABLE equals TIMEOUT: a pass on the last sample does not count as a fail.
   // A difference in the top bit alone must fail.
   task automatic test_stable_eq_timeout();
      expected2 = 32'hA5A5A5A5; obs2 = 32'hA5A5A5A5; start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         checks++; if (done2 !== (k == 4)) begin errors++; $display("[TB] FAIL eq_done_edge%0d: got %0b want %0b", k, done2, (k == 4)); end
      end
      checks++; if (pass2 !== 1'b1) begin errors++; $display("[TB] FAIL eq_pass: got %0b want 1", pass2); end
      checks++; if (fail_count2 !== 8'd0) begin errors++; $display("[TB] FAIL eq_fail_count: got %0d want 0", fail_count2); end
      @(posedge clk); #1;
      obs2 = 32'h25A5A5A5; start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      checks++; if (pass2 !== 1'b0) begin errors++; $display("[TB] FAIL eq_pass_cleared_on_start: got %0b want 0", pass2); end
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         checks++; if (done2 !== (k == 4)) begin errors++; $display("[TB] FAIL msb_done_edge%0d: got %0b want %0b", k, done2, (k == 4)); end
      end
      checks++; if (pass2 !== 1'b0) begin errors++; $display("[TB] FAIL msb_pass: got %0b want 0", pass2); end
      checks++; if (last_obs2 !== 32'h25A5A5A5) begin errors++; $display("[TB] FAIL msb_last_obs: got %h want 25a5a5a5", last_obs2); end
      checks++; if (fail_count2 !== 8'd1) begin errors++; $display("[TB] FAIL msb_fail_count: got %0d want 1", fail_count2); end
      @(posedge clk); #1;
   endtask

   // Reset mid-check aborts the check with no done pulse. The first start after reset is accepted.
   task automatic test_reset_abort();
      expected = 32'h04; obs = 32'h0F; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %0b want 0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL abort_pass: got %0b want 0", pass); end
      checks++; if (last_obs !== 32'h0) begin errors++; $display("[TB] FAIL abort_last_obs: got %h want 0", last_obs); end
      checks++; if (fail_count !== 8'd0) begin errors++; $display("[TB] FAIL abort_fail_count: got %0d want 0", fail_count); end
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done_edge%0d: got %0b want 0", k, done); end
      end
      @(negedge clk);
      reset = 1'b0;
      expected = 32'h19; obs = 32'h19; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_accept: got busy %0b want 1", busy); end
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         checks++; if (done !== (k == 3)) begin errors++; $display("[TB] FAIL post_reset_done_edge%0d: got %0b want %0b", k, done, (k == 3)); end
      end
      checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_pass: got %0b want 1", pass); end
      checks++; if (fail_count !== 8'd0) begin errors++; $display("[TB] FAIL post_reset_fail_count: got %0d want 0", fail_count); end
      @(posedge clk); #1;
   endtask

   // 256 failing checks: fail_count reaches 255 and stays there.
   task automatic test_saturate();
      int n;
      expected = 32'h04; obs = 32'h0F;
      for (int i = 1; i <= 256; i++) begin
         start = 1'b1;
         @(posedge clk); #1; start = 1'b0;
         n = 0;
         while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 40) begin
            checks++; errors++;
            $display("[TB] FAIL sat_timeout_check%0d: got no done within 40 cycles", i);
         end
         if (i == 254) begin
            checks++; if (fail_count !== 8'd254) begin errors++; $display("[TB] FAIL sat_254: got %0d want 254", fail_count); end
         end
         if (i == 255) begin
            checks++; if (fail_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_255: got %0d want 255", fail_count); end
         end
         if (i == 256) begin
            checks++; if (fail_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_256: got %0d want 255", fail_count); end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      expected  = 32'h0;
      obs       = 32'h0;
      start2    = 1'b0;
      expected2 = 32'h0;
      obs2      = 32'h0;
      test_reset();
      test_pass();
      test_fail();
      test_mid_start();
      test_stable_eq_timeout();
      test_reset_abort();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
